// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - UART receiver pin-side and host-side signal bundle
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output baud_tick, rx,
        input  data_out, data_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  baud_tick, rx,
        output data_out, data_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with parity and framing checks
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bad;
    logic                 expected_par;
    logic                 mid_bit;

    assign expected_par = (PARITY_ODD != 0) ? ~^shift_reg : ^shift_reg;
    assign mid_bit      = bus.baud_tick && (tick_cnt == FULL_CNT);
    assign bus.busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= S_IDLE;
            tick_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            par_bad        <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            rx_meta        <= bus.rx;
            rx_s           <= rx_meta;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                    par_bad  <= 1'b0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bus.baud_tick) begin
                        if (tick_cnt == HALF_CNT) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            // A high line at mid start bit is treated as noise
                            state    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (mid_bit) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else if (bus.baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (mid_bit) begin
                        tick_cnt <= '0;
                        par_bad  <= (rx_s != expected_par);
                        state    <= S_STOP;
                    end else if (bus.baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (mid_bit) begin
                        tick_cnt     <= '0;
                        bus.data_out <= shift_reg;
                        if (rx_s) begin
                            bus.data_valid <= !par_bad;
                            bus.parity_err <= par_bad;
                            state          <= S_IDLE;
                        end else begin
                            bus.frame_err <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end else if (bus.baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line recovers so a stuck-low rx cannot spawn frames
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [1:0] tick_div = 2'd0;
    logic       baud_tick = 1'b0;

    int errors = 0;
    int checks = 0;

    int va = 0, fa = 0, pa = 0, vb = 0, fb = 0, pb = 0;
    int viol = 0;
    bit busy_seen_a = 1'b0;
    logic [7:0] cap_a[$];
    logic prev_va = 1'b0, prev_fa = 1'b0, prev_pa = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_if #(.DATA_BITS(8)) bus_b ();

    assign bus_a.baud_tick = baud_tick;
    assign bus_a.rx        = rx_a;
    assign bus_b.baud_tick = baud_tick;
    assign bus_b.rx        = rx_b;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div  <= tick_div + 2'd1;
        baud_tick <= (tick_div == 2'd2);
    end

    always @(negedge clk) begin
        if (bus_a.data_valid) begin
            va++;
            cap_a.push_back(bus_a.data_out);
        end
        if (bus_a.frame_err)  fa++;
        if (bus_a.parity_err) pa++;
        if (bus_b.data_valid) vb++;
        if (bus_b.frame_err)  fb++;
        if (bus_b.parity_err) pb++;
        if (bus_a.busy) busy_seen_a = 1'b1;
        if ((int'(bus_a.data_valid) + int'(bus_a.frame_err) + int'(bus_a.parity_err)) > 1) viol++;
        if ((int'(bus_b.data_valid) + int'(bus_b.frame_err) + int'(bus_b.parity_err)) > 1) viol++;
        if ((bus_a.data_valid && prev_va) || (bus_a.frame_err && prev_fa) || (bus_a.parity_err && prev_pa)) viol++;
        prev_va = bus_a.data_valid;
        prev_fa = bus_a.frame_err;
        prev_pa = bus_a.parity_err;
    end

    task automatic clear_counts();
        @(posedge clk);
        va = 0; fa = 0; pa = 0; vb = 0; fb = 0; pb = 0;
        busy_seen_a = 1'b0;
        cap_a.delete();
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx_a = b;
        else          rx_b = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (with_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
        if (sel == 0) rx_a = 1'b1;
        else          rx_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.data_out !== 8'h00 || bus_a.data_valid !== 1'b0 || bus_a.frame_err !== 1'b0 ||
            bus_a.parity_err !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h valid=%b ferr=%b perr=%b busy=%b, required 00 0 0 0 0",
                     bus_a.data_out, bus_a.data_valid, bus_a.frame_err, bus_a.parity_err, bus_a.busy);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy_a=%b busy_b=%b, required 0 0", bus_a.busy, bus_b.busy);
        end
    endtask

    task automatic test_basic_a5();
        clear_counts();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (bus_a.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data: got %h, required a5", bus_a.data_out);
        end
        checks++;
        if (va != 1 || fa != 0 || pa != 0) begin
            errors++;
            $display("FAIL a5_pulses: valid=%0d ferr=%0d perr=%0d, required 1 0 0", va, fa, pa);
        end
        checks++;
        if (busy_seen_a !== 1'b1 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy: seen=%b now=%b, required 1 0", busy_seen_a, bus_a.busy);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx_a = 1'b0;
        repeat (12) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        checks++;
        if (va != 0 || fa != 0 || pa != 0) begin
            errors++;
            $display("FAIL glitch_pulses: valid=%0d ferr=%0d perr=%0d, required 0 0 0", va, fa, pa);
        end
        checks++;
        if (busy_seen_a !== 1'b1 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: seen=%b now=%b, required 1 0", busy_seen_a, bus_a.busy);
        end
        clear_counts();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (va != 1 || bus_a.data_out !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_next_frame: valid=%0d data=%h, required 1 3c", va, bus_a.data_out);
        end
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        rx_a = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b, required 1", bus_a.busy);
        end
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL break_release: busy=%b, required 0", bus_a.busy);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (fa != 1 || va != 0 || pa != 0) begin
            errors++;
            $display("FAIL ferr_pulses: valid=%0d ferr=%0d perr=%0d, required 0 1 0", va, fa, pa);
        end
        checks++;
        if (bus_a.data_out !== 8'h5A) begin
            errors++;
            $display("FAIL ferr_data: got %h, required 5a", bus_a.data_out);
        end
    endtask

    task automatic test_parity();
        clear_counts();
        send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (vb != 1 || pb != 0 || fb != 0 || bus_b.data_out !== 8'h37) begin
            errors++;
            $display("FAIL parity_good: valid=%0d perr=%0d ferr=%0d data=%h, required 1 0 0 37",
                     vb, pb, fb, bus_b.data_out);
        end
        clear_counts();
        send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (vb != 0 || pb != 1 || fb != 0) begin
            errors++;
            $display("FAIL parity_bad: valid=%0d perr=%0d ferr=%0d, required 0 1 0", vb, pb, fb);
        end
        checks++;
        if (bus_b.data_out !== 8'h37 || bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad_state: data=%h busy=%b, required 37 0", bus_b.data_out, bus_b.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first;
        logic [7:0] second;
        clear_counts();
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (va != 2 || fa != 0) begin
            errors++;
            $display("FAIL b2b_count: valid=%0d ferr=%0d, required 2 0", va, fa);
        end
        first  = (cap_a.size() > 0) ? cap_a[0] : 8'hxx;
        second = (cap_a.size() > 1) ? cap_a[1] : 8'hxx;
        checks++;
        if (first !== 8'h00 || second !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h %h, required 00 ff", first, second);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, i[0]);
        rx_a = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus_a.data_out !== 8'h00 || bus_a.busy !== 1'b0 || bus_a.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: data=%h busy=%b valid=%b, required 00 0 0",
                     bus_a.data_out, bus_a.busy, bus_a.data_valid);
        end
        repeat (3 * BIT_CLKS) @(negedge clk);
        checks++;
        if (va != 0 || fa != 0 || pa != 0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: valid=%0d ferr=%0d perr=%0d busy=%b, required 0 0 0 0",
                     va, fa, pa, bus_a.busy);
        end
        clear_counts();
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (va != 1 || bus_a.data_out !== 8'h81) begin
            errors++;
            $display("FAIL midrst_next_frame: valid=%0d data=%h, required 1 81", va, bus_a.data_out);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: violations=%0d, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
